cpu_core_p: RTL and testbench

- Parametrised successor of the team's fixed 8-bit CPU: a multi-cycle core with configurable data width and register count.
- Adds an instruction-fetch valid/ready handshake, a result strobe, ALU flags, branches and illegal-opcode detection.
- Sits between the instruction memory/driver and downstream observers of PC/RESULT.
- Instruction format is unchanged: OPCODE[31:24], DEST[23:16], SRC1[15:8], SRC2/IMM[7:0].

---
 rtl/cpu_core_p_pkg.sv | 31 +++
 rtl/cpu_core_p_regfile.sv | 32 +++
 rtl/cpu_core_p.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_core_p.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_core_p_pkg.sv
// Shared definitions for cpu_core_p: opcodes, FSM states, instruction field slices.
package cpu_core_p_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_SUB   = 8'h02;
  localparam logic [7:0] OP_AND   = 8'h03;
  localparam logic [7:0] OP_OR    = 8'h04;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_MUL   = 8'h08;

  typedef enum logic [1:0] {FETCH, EXEC, MUL} state_t;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 24;
  localparam int DST_HI  = 23;
  localparam int DST_LO  = 16;
  localparam int SRC1_HI = 15;
  localparam int SRC1_LO = 8;
  localparam int SRC2_HI = 7;
  localparam int SRC2_LO = 0;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Branch displacement in bytes: sign-extended word offset.
  function automatic logic [31:0] branch_offset(input logic [7:0] imm);
    return {{22{imm[7]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/cpu_core_p_regfile.sv
// NREGS x DATA_W register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear.
module cpu_core_p_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  localparam int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa] <= wd;
    end
  end

  assign rd_a = regs[ra];
  assign rd_b = regs[rb];

endmodule

// File: rtl/cpu_core_p.sv
// Multi-cycle parametrised core: FETCH/EXEC (+MUL) FSM with fetch handshake, retire strobe and flags.
// Optional shift-add multiplier (opcode 0x08) enabled by defining CPU_CORE_P_MUL_EN.
module cpu_core_p
  import cpu_core_p_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          NREGS    = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [31:0]       INSTRUCTION,
  input  logic              INSTR_VALID,
  output logic              INSTR_READY,
  output logic [31:0]       PC,
  output logic [DATA_W-1:0] RESULT,
  output logic              RESULT_VALID,
  output logic              ZERO,
  output logic              CARRY,
  output logic              ILLEGAL
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t            state;
  logic [31:0]       instr;
  logic [7:0]        opc, dst, src1, src2;
  logic [AW-1:0]     ra, rb;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W:0]   sum;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wd;

  logic              op_ok, need_d, need_1, need_2, bad, wr, upd_z, c_nxt;
  logic [DATA_W-1:0] alu;
  logic [31:0]       pc_nxt;

  assign opc  = instr[OPC_HI:OPC_LO];
  assign dst  = instr[DST_HI:DST_LO];
  assign src1 = instr[SRC1_HI:SRC1_LO];
  assign src2 = instr[SRC2_HI:SRC2_LO];

  // BEQ compares DEST with SRC1, so the read ports are steered accordingly.
  assign ra  = (opc == OP_BEQ) ? dst[AW-1:0]  : src1[AW-1:0];
  assign rb  = (opc == OP_BEQ) ? src1[AW-1:0] : src2[AW-1:0];
  assign sum = {1'b0, rd_a} + {1'b0, rd_b};

`ifdef CPU_CORE_P_MUL_EN
  localparam int CW = $clog2(DATA_W + 1);
  logic [2*DATA_W-1:0] acc, mcand, acc_nxt;
  logic [DATA_W-1:0]   mplier;
  logic [CW-1:0]       cnt;
  logic                mul_last;

  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == CW'(DATA_W - 1));
`endif

  always_comb begin
    op_ok  = 1'b1;
    need_d = 1'b0;
    need_1 = 1'b0;
    need_2 = 1'b0;
    wr     = 1'b0;
    upd_z  = 1'b0;
    c_nxt  = CARRY;
    alu    = RESULT;
    pc_nxt = PC + PC_STEP;
    case (opc)
      OP_LOADI: begin wr = 1'b1; need_d = 1'b1; alu = DATA_W'(src2); end
      OP_ADD: begin
        wr = 1'b1; upd_z = 1'b1; need_d = 1'b1; need_1 = 1'b1; need_2 = 1'b1;
        alu = sum[DATA_W-1:0]; c_nxt = sum[DATA_W];
      end
      OP_SUB: begin
        wr = 1'b1; upd_z = 1'b1; need_d = 1'b1; need_1 = 1'b1; need_2 = 1'b1;
        alu = rd_a - rd_b; c_nxt = (rd_a < rd_b);
      end
      OP_AND: begin
        wr = 1'b1; upd_z = 1'b1; need_d = 1'b1; need_1 = 1'b1; need_2 = 1'b1;
        alu = rd_a & rd_b; c_nxt = 1'b0;
      end
      OP_OR: begin
        wr = 1'b1; upd_z = 1'b1; need_d = 1'b1; need_1 = 1'b1; need_2 = 1'b1;
        alu = rd_a | rd_b; c_nxt = 1'b0;
      end
      OP_J:   pc_nxt = {22'b0, src2, 2'b00};
      OP_BEQ: begin
        need_d = 1'b1; need_1 = 1'b1;
        if (rd_a == rd_b) pc_nxt = PC + PC_STEP + branch_offset(src2);
      end
`ifdef CPU_CORE_P_MUL_EN
      OP_MUL: begin need_d = 1'b1; need_1 = 1'b1; need_2 = 1'b1; end
`endif
      default: op_ok = 1'b0;
    endcase
    bad = !op_ok || (need_d && 32'(dst) >= NREGS) ||
          (need_1 && 32'(src1) >= NREGS) || (need_2 && 32'(src2) >= NREGS);
  end

  always_comb begin
    rf_we = (state == EXEC) && wr && !bad;
    rf_wd = alu;
`ifdef CPU_CORE_P_MUL_EN
    if (state == MUL && mul_last) begin
      rf_we = 1'b1;
      rf_wd = acc_nxt[DATA_W-1:0];
    end
`endif
  end

  cpu_core_p_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk   (CLK),
    .rst_n (RESET_N),
    .we    (rf_we),
    .wa    (dst[AW-1:0]),
    .wd    (rf_wd),
    .ra    (ra),
    .rb    (rb),
    .rd_a  (rd_a),
    .rd_b  (rd_b)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= FETCH;
      instr        <= '0;
      INSTR_READY  <= 1'b1;
      PC           <= RESET_PC;
      RESULT       <= '0;
      RESULT_VALID <= 1'b0;
      ZERO         <= 1'b0;
      CARRY        <= 1'b0;
      ILLEGAL      <= 1'b0;
`ifdef CPU_CORE_P_MUL_EN
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      RESULT_VALID <= 1'b0;
      case (state)
        FETCH: if (INSTR_VALID) begin
          instr       <= INSTRUCTION;
          state       <= EXEC;
          INSTR_READY <= 1'b0;
        end
        EXEC: begin
          if (bad) begin
            ILLEGAL      <= 1'b1;
            PC           <= PC + PC_STEP;
            RESULT_VALID <= 1'b1;
            state        <= FETCH;
            INSTR_READY  <= 1'b1;
          end
`ifdef CPU_CORE_P_MUL_EN
          else if (opc == OP_MUL) begin
            acc    <= '0;
            mcand  <= {{DATA_W{1'b0}}, rd_a};
            mplier <= rd_b;
            cnt    <= '0;
            state  <= MUL;
          end
`endif
          else begin
            PC <= pc_nxt;
            if (wr)    RESULT <= alu;
            if (upd_z) ZERO   <= (alu == '0);
            CARRY        <= c_nxt;
            RESULT_VALID <= 1'b1;
            state        <= FETCH;
            INSTR_READY  <= 1'b1;
          end
        end
`ifdef CPU_CORE_P_MUL_EN
        MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            RESULT       <= acc_nxt[DATA_W-1:0];
            ZERO         <= (acc_nxt[DATA_W-1:0] == '0);
            CARRY        <= |acc_nxt[2*DATA_W-1:DATA_W];
            PC           <= PC + PC_STEP;
            RESULT_VALID <= 1'b1;
            state        <= FETCH;
            INSTR_READY  <= 1'b1;
          end
        end
`endif
        default: begin
          state       <= FETCH;
          INSTR_READY <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_p.sv
// Scoreboard bench for cpu_core_p: an 8-bit and a 16-bit instance, directed instruction vectors.
module tb_cpu_core_p;

  typedef struct packed {
    logic [15:0] res;
    logic [31:0] pc;
    logic        z;
    logic        c;
    logic        il;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ins8, ins16;
  logic        v8, v16;
  logic        rdy8, rv8, z8, c8, il8;
  logic        rdy16, rv16, z16, c16, il16;
  logic [31:0] pc8, pc16;
  logic [7:0]  res8;
  logic [15:0] res16;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  cpu_core_p #(.DATA_W(8)) dut8 (
    .CLK(clk), .RESET_N(rst_n), .INSTRUCTION(ins8), .INSTR_VALID(v8), .INSTR_READY(rdy8),
    .PC(pc8), .RESULT(res8), .RESULT_VALID(rv8), .ZERO(z8), .CARRY(c8), .ILLEGAL(il8)
  );

  cpu_core_p #(.DATA_W(16)) dut16 (
    .CLK(clk), .RESET_N(rst_n), .INSTRUCTION(ins16), .INSTR_VALID(v16), .INSTR_READY(rdy16),
    .PC(pc16), .RESULT(res16), .RESULT_VALID(rv16), .ZERO(z16), .CARRY(c16), .ILLEGAL(il16)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitors: every retire strobe consumes one expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rv8 === 1'b1) begin
      checks++;
      if (q8.size() == 0) begin
        $display("FAIL retire8_unexpected: retire at pc %h with no expected entry", pc8);
      end else begin
        e8 = q8.pop_front();
        if ({res8, pc8, z8, c8, il8} === {e8.res[7:0], e8.pc, e8.z, e8.c, e8.il}) passed++;
        else $display("FAIL retire8: got res=%h pc=%h z=%b c=%b il=%b expected res=%h pc=%h z=%b c=%b il=%b",
                      res8, pc8, z8, c8, il8, e8.res[7:0], e8.pc, e8.z, e8.c, e8.il);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rv16 === 1'b1) begin
      checks++;
      if (q16.size() == 0) begin
        $display("FAIL retire16_unexpected: retire at pc %h with no expected entry", pc16);
      end else begin
        e16 = q16.pop_front();
        if ({res16, pc16, z16, c16, il16} === {e16.res, e16.pc, e16.z, e16.c, e16.il}) passed++;
        else $display("FAIL retire16: got res=%h pc=%h z=%b c=%b il=%b expected res=%h pc=%h z=%b c=%b il=%b",
                      res16, pc16, z16, c16, il16, e16.res, e16.pc, e16.z, e16.c, e16.il);
      end
    end
  end

  // Waits (bounded) for ready, then holds valid across exactly one rising edge.
  task automatic issue(input bit w16, input logic [31:0] ins);
    int n = 0;
    @(negedge clk);
    while ((w16 ? rdy16 : rdy8) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((w16 ? rdy16 : rdy8) !== 1'b1) begin
      checks++;
      $display("FAIL issue_timeout: ready %b required 1", w16 ? rdy16 : rdy8);
    end
    if (w16) begin ins16 = ins; v16 = 1'b1; end
    else     begin ins8  = ins; v8  = 1'b1; end
    @(posedge clk);
    #1;
    v8  = 1'b0;
    v16 = 1'b0;
  endtask

  logic [31:0] ti [17] = '{
    32'h0000002A, 32'h01010000, 32'h02020100, 32'h03030200, 32'h04040300, 32'h05050400,
    32'h01060505, 32'h070000FE, 32'h06000010, 32'h070006FE, 32'h000100FF, 32'h00020001,
    32'h01030102, 32'h02040201, 32'h00090007, 32'h04050301, 32'h01060500
  };
  exp_t te [17] = '{
    '{16'h002A, 32'd4,  1'b0, 1'b0, 1'b0},
    '{16'h0054, 32'd8,  1'b0, 1'b0, 1'b0},
    '{16'h002A, 32'd12, 1'b0, 1'b0, 1'b0},
    '{16'h002A, 32'd16, 1'b0, 1'b0, 1'b0},
    '{16'h002A, 32'd20, 1'b0, 1'b0, 1'b0},
    '{16'h002A, 32'd24, 1'b0, 1'b0, 1'b1},
    '{16'h0000, 32'd28, 1'b1, 1'b0, 1'b1},
    '{16'h0000, 32'd24, 1'b1, 1'b0, 1'b1},
    '{16'h0000, 32'd64, 1'b1, 1'b0, 1'b1},
    '{16'h0000, 32'd68, 1'b1, 1'b0, 1'b1},
    '{16'h00FF, 32'd72, 1'b1, 1'b0, 1'b1},
    '{16'h0001, 32'd76, 1'b1, 1'b0, 1'b1},
    '{16'h0000, 32'd80, 1'b1, 1'b1, 1'b1},
    '{16'h0002, 32'd84, 1'b0, 1'b1, 1'b1},
    '{16'h0002, 32'd88, 1'b0, 1'b1, 1'b1},
    '{16'h00FF, 32'd92, 1'b0, 1'b0, 1'b1},
    '{16'h0029, 32'd96, 1'b0, 1'b1, 1'b1}
  };

  logic [31:0] t16i [3] = '{32'h000100FF, 32'h00020001, 32'h01030102};
  exp_t t16e [3] = '{
    '{16'h00FF, 32'd4,  1'b0, 1'b0, 1'b0},
    '{16'h0001, 32'd8,  1'b0, 1'b0, 1'b0},
    '{16'h0100, 32'd12, 1'b0, 1'b0, 1'b0}
  };

  task automatic reset_checks(input string tag);
    chk({tag, "_pc"}, pc8, 32'd0);
    chk({tag, "_result"}, {24'd0, res8}, 32'd0);
    chk({tag, "_flags_zcil_rv"}, {28'd0, z8, c8, il8, rv8}, 32'd0);
    chk({tag, "_ready"}, {31'd0, rdy8}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    v8 = 1'b0; v16 = 1'b0; ins8 = '0; ins16 = '0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      q16.push_back(t16e[i]);
      issue(1'b1, t16i[i]);
    end

    for (int i = 0; i < 17; i++) begin
      q8.push_back(te[i]);
      issue(1'b0, ti[i]);
      if (i == 0) begin
        // Retire strobe: low during EXEC, high for exactly the following cycle.
        @(negedge clk); chk("rv_exec_cycle", {31'd0, rv8}, 32'd0);
        @(negedge clk); chk("rv_retire_cycle", {31'd0, rv8}, 32'd1);
        @(negedge clk); chk("rv_after_retire", {31'd0, rv8}, 32'd0);
      end
      if (i == 15) begin
        repeat (2) @(negedge clk);
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_pc", pc8, 32'd92);
        end
      end
    end

`ifdef CPU_CORE_P_MUL_EN
    begin
      int lows;
      q8.push_back('{16'h0007, 32'd100, 1'b0, 1'b1, 1'b1}); issue(1'b0, 32'h00010007);
      q8.push_back('{16'h0006, 32'd104, 1'b0, 1'b1, 1'b1}); issue(1'b0, 32'h00020006);
      q8.push_back('{16'h002A, 32'd108, 1'b0, 1'b0, 1'b1}); issue(1'b0, 32'h08030102);
      lows = 0;
      while (rdy8 !== 1'b1 && lows < 100) begin
        @(negedge clk);
        if (rdy8 !== 1'b1) lows++;
      end
      chk("mul_ready_low_cycles", lows, 32'd9);
      q8.push_back('{16'h0020, 32'd112, 1'b0, 1'b0, 1'b1}); issue(1'b0, 32'h00010020);
      q8.push_back('{16'h0010, 32'd116, 1'b0, 1'b0, 1'b1}); issue(1'b0, 32'h00020010);
      q8.push_back('{16'h0000, 32'd120, 1'b1, 1'b1, 1'b1}); issue(1'b0, 32'h08030102);
      issue(1'b0, 32'h08030102);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      reset_checks("mul_abort");
      rst_n = 1'b1;
    end
`endif

    // Reset during EXEC: nothing retires, state returns to reset values.
    issue(1'b0, 32'h00070055);
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("exec_abort");
    rst_n = 1'b1;

`ifdef CPU_CORE_P_MUL_EN
    q8.push_back('{16'h0000, 32'd4, 1'b1, 1'b0, 1'b0});
`else
    q8.push_back('{16'h0000, 32'd4, 1'b0, 1'b0, 1'b1});
`endif
    issue(1'b0, 32'h08030102);

    for (int n = 0; n < 100 && (q8.size() != 0 || q16.size() != 0); n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("queues_drained", q8.size() + q16.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
